// File: rtl/parity_frame_rx.sv
// Even-parity serial frame receiver: start, LSB-first data, parity, stop.
// Reports the recovered word, parity/framing errors and saturating counters.
module parity_frame_rx #(
  parameter int DATA_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              din_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam int BCW = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0] LAST = BCW'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic [1:0]        r_state;
  logic [1:0]        w_state_nx;
  logic [BCW-1:0]    r_bcnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nx;
  logic              r_par;
  logic              r_busy;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_perr;
  logic              r_ferr;
  logic [CNT_W-1:0]  r_fcnt;
  logic [CNT_W-1:0]  r_ecnt;

  logic w_idle;
  logic w_data;
  logic w_parity;
  logic w_stop;
  logic w_last;
  logic w_perr;
  logic w_ferr;
  logic w_done;

  assign w_idle   = (r_state == IDLE);
  assign w_data   = (r_state == DATA);
  assign w_parity = (r_state == PARITY);
  assign w_stop   = (r_state == STOP);
  assign w_last   = (r_bcnt == LAST);

  // First bit received must end up at bit 0.
  generate
    if (DATA_W == 1) begin : g_sh1
      assign w_shift_nx = din;
    end else begin : g_shn
      assign w_shift_nx = {din, r_shift[DATA_W-1:1]};
    end
  endgenerate

  assign w_perr = ^{r_shift, r_par};
  assign w_ferr = ~din;
  assign w_done = din_valid & w_stop;

  always_comb begin
    w_state_nx = r_state;
    if (din_valid) begin
      unique case (1'b1)
        w_idle:   if (!din) w_state_nx = DATA;
        w_data:   if (w_last) w_state_nx = PARITY;
        w_parity: w_state_nx = STOP;
        w_stop:   w_state_nx = IDLE;
        default:  w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_bcnt  <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else if (din_valid) begin
      r_state <= w_state_nx;
      r_busy  <= (w_state_nx != IDLE);
      if (w_idle && !din) r_bcnt <= '0;
      if (w_data) begin
        r_shift <= w_shift_nx;
        r_bcnt  <= r_bcnt + 1'b1;
      end
      if (w_parity) r_par <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_fcnt  <= '0;
      r_ecnt  <= '0;
    end else begin
      r_valid <= w_done;
      if (w_done) begin
        r_data <= r_shift;
        r_perr <= w_perr;
        r_ferr <= w_ferr;
        if (r_fcnt != CMAX) r_fcnt <= r_fcnt + 1'b1;
        if ((w_perr || w_ferr) && (r_ecnt != CMAX))
          r_ecnt <= r_ecnt + 1'b1;
      end
    end
  end

  assign data_out   = r_data;
  assign out_valid  = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = r_busy;
  assign frame_cnt  = r_fcnt;
  assign err_cnt    = r_ecnt;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: fixed vectors, corner sequences and random
// traffic against a frame-level reference model (two counter widths).
module tb_parity_frame_rx;

  localparam int DW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b1;
  logic din_valid = 1'b0;

  logic [DW-1:0] data_out, s_data_out;
  logic out_valid, s_out_valid;
  logic parity_err, s_parity_err;
  logic frame_err, s_frame_err;
  logic busy, s_busy;
  logic [7:0] frame_cnt, err_cnt;
  logic [1:0] s_frame_cnt, s_err_cnt;

  always #5 clk = ~clk;

  parity_frame_rx #(.DATA_W(DW), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .data_out(data_out), .out_valid(out_valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  parity_frame_rx #(.DATA_W(DW), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .data_out(s_data_out), .out_valid(s_out_valid),
    .parity_err(s_parity_err), .frame_err(s_frame_err), .busy(s_busy),
    .frame_cnt(s_frame_cnt), .err_cnt(s_err_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model: collect qualified samples after a start bit.
  bit m_in;
  bit m_q[$];
  logic [DW-1:0] m_data;
  bit m_perr, m_ferr, m_valid;
  int m_fc, m_ec, m_fc2, m_ec2;

  task automatic model_reset();
    m_in = 0; m_q.delete(); m_data = '0;
    m_perr = 0; m_ferr = 0; m_valid = 0;
    m_fc = 0; m_ec = 0; m_fc2 = 0; m_ec2 = 0;
  endtask

  task automatic model_step(input bit d, input bit v);
    int ones;
    m_valid = 0;
    if (v) begin
      if (!m_in) begin
        if (!d) begin
          m_in = 1;
          m_q.delete();
        end
      end else begin
        m_q.push_back(d);
        if (m_q.size() == DW + 2) begin
          ones = 0;
          for (int i = 0; i < DW; i++) begin
            m_data[i] = m_q[i];
            ones += int'(m_q[i]);
          end
          ones += int'(m_q[DW]);
          m_perr = (ones % 2) != 0;
          m_ferr = (m_q[DW+1] == 1'b0);
          m_valid = 1;
          m_in = 0;
          if (m_fc < 255) m_fc++;
          if (m_fc2 < 3) m_fc2++;
          if (m_perr || m_ferr) begin
            if (m_ec < 255) m_ec++;
            if (m_ec2 < 3) m_ec2++;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, m_valid);
    chk("busy", busy, m_in);
    chk("data_out", data_out, m_data);
    chk("parity_err", parity_err, m_perr);
    chk("frame_err", frame_err, m_ferr);
    chk("frame_cnt", frame_cnt, m_fc);
    chk("err_cnt", err_cnt, m_ec);
    chk("s_out_valid", s_out_valid, m_valid);
    chk("s_frame_cnt", s_frame_cnt, m_fc2);
    chk("s_err_cnt", s_err_cnt, m_ec2);
  endtask

  task automatic step(input bit d, input bit v);
    din = d;
    din_valid = v;
    model_step(d, v);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send(input logic [0:5] seq);
    for (int j = 0; j < 6; j++) step(seq[j], 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [0:5]    seq;
    logic [DW-1:0] data;
    logic          perr;
    logic          ferr;
  } vec_t;

  vec_t tbl[3];

  initial begin
    tbl[0] = '{seq: 6'b010101, data: 3'b101, perr: 1'b0, ferr: 1'b0};
    tbl[1] = '{seq: 6'b011011, data: 3'b011, perr: 1'b1, ferr: 1'b0};
    tbl[2] = '{seq: 6'b010010, data: 3'b001, perr: 1'b0, ferr: 1'b1};

    model_reset();
    #2;
    chk("rst data_out", data_out, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst parity_err", parity_err, 0);
    chk("rst frame_err", frame_err, 0);
    chk("rst busy", busy, 0);
    chk("rst frame_cnt", frame_cnt, 0);
    chk("rst err_cnt", err_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 3; k++) begin
      send(tbl[k].seq);
      chk("vec out_valid", out_valid, 1);
      chk("vec data_out", data_out, tbl[k].data);
      chk("vec parity_err", parity_err, tbl[k].perr);
      chk("vec frame_err", frame_err, tbl[k].ferr);
      chk("vec frame_cnt", frame_cnt, k + 1);
      step(1'b1, 1'b1);
      chk("vec pulse width", out_valid, 0);
    end
    chk("vec err_cnt", err_cnt, 2);

    // Idle line plus stalls carrying garbage.
    for (int j = 0; j < 3; j++) step(1'b1, 1'b1);
    for (int j = 0; j < 6; j++) begin
      step(tbl[0].seq[j], 1'b1);
      if (j < 5) begin
        step(1'($urandom_range(0, 1)), 1'b0);
        step(1'($urandom_range(0, 1)), 1'b0);
      end
    end
    chk("stall out_valid", out_valid, 1);
    chk("stall data_out", data_out, 3'b101);
    chk("stall parity_err", parity_err, 0);
    chk("stall frame_cnt", frame_cnt, 4);

    // Reset after the second data bit.
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("mid busy", busy, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid rst busy", busy, 0);
    chk("mid rst frame_cnt", frame_cnt, 0);
    chk("mid rst data_out", data_out, 0);
    for (int j = 0; j < 3; j++) begin
      din = 1'b1;
      din_valid = 1'b1;
      @(posedge clk);
      #1;
      check_all();
    end
    rst_n = 1'b1;
    send(tbl[0].seq);
    chk("post rst data_out", data_out, 3'b101);
    chk("post rst frame_cnt", frame_cnt, 1);

    // Saturation on the 2-bit counter instance.
    do_reset();
    for (int k = 0; k < 5; k++) send(tbl[1].seq);
    chk("sat frame_cnt", s_frame_cnt, 3);
    chk("sat err_cnt", s_err_cnt, 3);
    chk("wide frame_cnt", frame_cnt, 5);

    // Back-to-back frames with no gap.
    send(tbl[0].seq);
    chk("b2b first data", data_out, 3'b101);
    send(tbl[2].seq);
    chk("b2b second data", data_out, 3'b001);
    chk("b2b second ferr", frame_err, 1);
    chk("b2b frame_cnt", frame_cnt, 7);

    for (int n = 0; n < 600; n++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_frame_rx.md
# parity_frame_rx

Serial receiver and checker for even-parity frames produced by the parity generator path. The generator drives a parity bit of 1 when its 3-bit word has an odd number of ones, so every valid frame has an even total count of ones across data and parity. This block deserialises start, data, parity and stop bits on qualified clock edges, presents the recovered word, and flags parity and framing errors. It also keeps saturating frame and error counters for lab observation.

## Interface
- DATA_W, 3, data bits per frame (1..8)
- CNT_W, 8, width of frame and error counters
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- din  input  1  serial line bit
- din_valid  input  1  din is sampled only on edges where this is 1
- data_out  output  DATA_W  last received word, LSB received first
- out_valid  output  1  one-cycle pulse when a frame completes
- parity_err  output  1  last frame failed even parity; held until next frame completes
- frame_err  output  1  last frame's stop bit was 0; held until next frame completes
- busy  output  1  high in any state other than IDLE
- frame_cnt  output  CNT_W  completed frames, saturating
- err_cnt  output  CNT_W  frames with parity_err or frame_err, saturating

## Operation
- Frame format on qualified samples: start bit 0, then DATA_W data bits LSB first, then parity bit, then stop bit 1.
- Parity check: parity_err = XOR of the DATA_W data bits and the parity bit. A valid frame gives 0.
- The FSM advances only on edges with din_valid=1. With din_valid=0, all state, shift register and bit counter hold.
- IDLE:
  - din=0 goes to DATA and clears the bit counter.
  - din=1 stays in IDLE, so an idle line is ignored.
- DATA:
  - Shift din into a DATA_W shift register from the MSB end, so the first bit received ends at bit 0.
  - Increment the bit counter. After DATA_W bits, go to PARITY.
- PARITY: latch din as the parity bit, then go to STOP.
- STOP: sample the stop bit, complete the frame and return to IDLE. There is no extra idle bit, so a start bit may follow on the next qualified sample.
- On frame completion, the following update together:
  - data_out loads from the shift register.
  - parity_err loads the parity XOR.
  - frame_err loads ~din.
  - out_valid pulses.
  - frame_cnt increments.
  - err_cnt increments if either error is set.
- A frame with a framing error still updates data_out.
- Both counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- Reset values: data_out=0, out_valid=0, parity_err=0, frame_err=0, busy=0, frame_cnt=0, err_cnt=0, FSM=IDLE, shift register=0, bit counter=0.
- Reset is asynchronous. Asserting rst_n=0 mid-frame aborts the frame immediately: no out_valid and no counter change.
- All outputs are registered.
- Latency: out_valid=1 in the cycle after the edge that samples the stop bit, and for exactly one cycle.
- A frame takes DATA_W+3 qualified samples (start, data, parity, stop). With din_valid held at 1, that is 6 cycles for DATA_W=3.
- busy rises in the cycle after the start bit is sampled. It falls in the same cycle that out_valid rises.
- Back-to-back frames: a start bit on the first qualified sample after the stop bit is accepted with no gap.
- data_out, parity_err and frame_err are stable between out_valid pulses.

## Test plan
- Good frame, din_valid=1 throughout, din=0,1,0,1,0,1 (data 3'b101, parity 0, stop 1):
  - out_valid pulses once, data_out=3'b101, parity_err=0, frame_err=0.
  - frame_cnt=1, err_cnt=0.
- Parity error, din=0,1,1,0,1,1 (data 3'b011, wrong parity 1):
  - data_out=3'b011, parity_err=1, frame_err=0, err_cnt=1.
- Framing error, din=0,1,0,0,1,0 (data 3'b001, parity 1 correct, stop 0):
  - data_out=3'b001, parity_err=0, frame_err=1, err_cnt increments.
- Stall and idle:
  - Leading din=1 samples are ignored.
  - The good frame from scenario 1 is interleaved with din_valid=0 cycles carrying garbage on din.
  - Result is identical to scenario 1, with out_valid delayed by the stall cycles.
- Reset mid-frame:
  - Assert rst_n=0 after the second data bit: outputs reach their reset values immediately and there is no out_valid.
  - After release, a full good frame decodes correctly and frame_cnt=1.
- Saturation, CNT_W=2:
  - Send 5 parity-error frames: frame_cnt=3, err_cnt=3, holding at 3 with no wrap.
  - Two frames sent back-to-back with no gap both decode.
